// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream encoder/checker.
//   crc_state_t         : transaction FSM states
//   CRC14_POLY / _INIT  : default CRC-14 generator (x^14+x^10+x^8+x^7+x^4+x^3+1) and seed
//   MODE_ENC / MODE_CHK : values of in_mode
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_t;

  localparam logic [13:0] CRC14_POLY = 14'h0599;
  localparam logic [13:0] CRC14_INIT = 14'h0000;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/crc_stream_encoder_if.sv
// Request/response bus of the CRC stream encoder.
//   in_valid/in_ready/in_mode/in_data   : request (message or codeword)
//   out_valid/out_ready/out_data/out_err: response ({msg, crc} or codeword + error flag)
// master = producer of requests / consumer of responses, slave = the encoder.
interface crc_stream_encoder_if #(
  parameter int unsigned MSG_W = 8,
  parameter int unsigned CRC_W = 14
);

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [MSG_W+CRC_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [MSG_W+CRC_W-1:0] out_data;
  logic                   out_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/crc_chunk_step.sv
// Combinational fold of CHUNK_W message bits (MSB first) into a CRC register.
//   crc_in  : CRC value before the chunk
//   chunk   : message bits, bit CHUNK_W-1 is processed first
//   crc_out : CRC value after all CHUNK_W bits
module crc_chunk_step #(
  parameter int unsigned           CRC_W   = 14,
  parameter logic [CRC_W-1:0]      POLY    = CRC_W'(14'h0599),
  parameter int unsigned           CHUNK_W = 8
) (
  input  logic [CRC_W-1:0]   crc_in,
  input  logic [CHUNK_W-1:0] chunk,
  output logic [CRC_W-1:0]   crc_out
);

  // One stage per bit; each stage reads the previous stage's result.
  for (genvar i = 0; i < CHUNK_W; i++) begin : g_bit
    logic [CRC_W-1:0] prev;
    logic [CRC_W-1:0] nxt;
    logic             fb;

    if (i == 0) begin : g_first
      assign prev = crc_in;
    end else begin : g_chain
      assign prev = g_bit[i-1].nxt;
    end

    assign fb  = chunk[CHUNK_W-1-i] ^ prev[CRC_W-1];
    assign nxt = {prev[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  assign crc_out = g_bit[CHUNK_W-1].nxt;

endmodule

// File: rtl/crc_stream_encoder.sv
// CRC encoder/checker with valid/ready request and response ports.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of crc_stream_encoder_if
// Encode returns {msg, crc(msg)}; check returns the codeword unchanged and
// flags out_err when crc(msg) differs from the received CRC field.
module crc_stream_encoder
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W   = 14,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC14_POLY),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(CRC14_INIT),
  parameter int unsigned      MSG_W   = 8,
  parameter int unsigned      CHUNK_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  crc_stream_encoder_if.slave bus
);

  localparam int unsigned N      = MSG_W / CHUNK_W;
  localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DATA_W = MSG_W + CRC_W;

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  if ((MSG_W % CHUNK_W) != 0) begin : g_bad_chunk
    $error("MSG_W must be a multiple of CHUNK_W");
  end

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [CRC_W-1:0]  crc_q,       crc_d;
  logic [MSG_W-1:0]  msg_q,       msg_d;
  logic [MSG_W-1:0]  sh_q,        sh_d;
  logic [CRC_W-1:0]  rxcrc_q,     rxcrc_d;
  logic              mode_q,      mode_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_err_q,   out_err_d;
  logic [CRC_W-1:0]  crc_step_c;

  // Next chunk always sits at the top of the shift copy of the message.
  crc_chunk_step #(
    .CRC_W   (CRC_W),
    .POLY    (POLY),
    .CHUNK_W (CHUNK_W)
  ) u_step (
    .crc_in  (crc_q),
    .chunk   (sh_q[MSG_W-1 -: CHUNK_W]),
    .crc_out (crc_step_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      crc_q       <= INIT;
      msg_q       <= '0;
      sh_q        <= '0;
      rxcrc_q     <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      msg_q       <= msg_d;
      sh_q        <= sh_d;
      rxcrc_q     <= rxcrc_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  // Next-state and result logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    msg_d       = msg_q;
    sh_d        = sh_q;
    rxcrc_d     = rxcrc_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          msg_d   = bus.in_data[DATA_W-1:CRC_W];
          sh_d    = bus.in_data[DATA_W-1:CRC_W];
          rxcrc_d = bus.in_data[CRC_W-1:0];
          mode_d  = bus.in_mode;
          crc_d   = INIT;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        crc_d = crc_step_c;
        sh_d  = sh_q << CHUNK_W;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          // Result is taken from the step output so no extra cycle is spent.
          out_valid_d = 1'b1;
          out_data_d  = (mode_q == MODE_CHK) ? {msg_q, rxcrc_q} : {msg_q, crc_step_c};
          out_err_d   = (mode_q == MODE_CHK) && (crc_step_c != rxcrc_q);
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_crc_stream_encoder.sv
// Bench for crc_stream_encoder: instance A (CHUNK_W=8) is scoreboarded every
// cycle against a bitwise CRC model; instance B (CHUNK_W=4) is checked directly.
module tb_crc_stream_encoder;
  import crc_pkg::*;

  localparam int unsigned DATA_W = 22;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc_stream_encoder_if #(.MSG_W(8), .CRC_W(14)) bus_a ();
  crc_stream_encoder_if #(.MSG_W(8), .CRC_W(14)) bus_b ();

  crc_stream_encoder #(
    .CRC_W(14), .POLY(14'h0599), .INIT(14'h0000), .MSG_W(8), .CHUNK_W(8)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  crc_stream_encoder #(
    .CRC_W(14), .POLY(14'h0599), .INIT(14'h0000), .MSG_W(8), .CHUNK_W(4)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // CRC-14, MSB first, seed 0, no reflection or final XOR.
  function automatic logic [13:0] crc_of(input logic [7:0] m);
    logic [13:0] c;
    logic        fb;
    c = 14'h0000;
    for (int i = 7; i >= 0; i--) begin
      fb = m[i] ^ c[13];
      c  = {c[12:0], 1'b0} ^ (fb ? 14'h0599 : 14'h0000);
    end
    return c;
  endfunction

  // Expected {out_err, out_data} for one request.
  function automatic logic [22:0] model(input logic m, input logic [21:0] d);
    logic [7:0]  msg;
    logic [13:0] c;
    msg = d[21:14];
    c   = crc_of(msg);
    if (m == MODE_ENC) return {1'b0, msg, c};
    return {(c != d[13:0]), d};
  endfunction

  // Scoreboard for instance A.
  logic [22:0] exp_q[$];
  int          t_q[$];
  int          cyc = 0;
  logic        prev_valid = 1'b0;
  int          acc_a = 0;
  int          done_a = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      t_q.delete();
      prev_valid = 1'b0;
      check("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
      check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
      check("rst_out_data",  64'(bus_a.out_data),  64'd0);
      check("rst_out_err",   64'(bus_a.out_err),   64'd0);
    end else begin
      if (bus_a.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          check("sb_out_data", 64'(bus_a.out_data), 64'(exp_q[0][21:0]));
          check("sb_out_err",  64'(bus_a.out_err),  64'(exp_q[0][22]));
          check("sb_in_ready_busy", 64'(bus_a.in_ready), 64'd0);
          if (!prev_valid) check("sb_latency", 64'(cyc - t_q[0]), 64'd2);
          if (bus_a.out_ready) begin
            void'(exp_q.pop_front());
            void'(t_q.pop_front());
            done_a++;
          end
        end
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
        exp_q.push_back(model(bus_a.in_mode, bus_a.in_data));
        t_q.push_back(cyc);
        acc_a++;
      end
      prev_valid = bus_a.out_valid;
    end
  end

  task automatic send_a(input logic m, input logic [21:0] d);
    int n = 0;
    while (!bus_a.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_a.in_ready) check("send_a_timeout", 64'd0, 64'd1);
    bus_a.in_valid = 1'b1;
    bus_a.in_mode  = m;
    bus_a.in_data  = d;
    @(posedge clk); #1;
    // Garbage while busy must not affect the result.
    bus_a.in_valid = 1'b0;
    bus_a.in_mode  = ~m;
    bus_a.in_data  = ~d;
  endtask

  task automatic wait_a(output logic [21:0] d, output logic e);
    int n = 0;
    while (!bus_a.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_a.out_valid) check("wait_a_timeout", 64'd0, 64'd1);
    d = bus_a.out_data;
    e = bus_a.out_err;
  endtask

  task automatic txn_a(input string name, input logic m, input logic [21:0] d,
                       input logic [21:0] exp_d, input logic exp_e);
    logic [21:0] got_d;
    logic        got_e;
    send_a(m, d);
    wait_a(got_d, got_e);
    check({name, "_data"}, 64'(got_d), 64'(exp_d));
    check({name, "_err"},  64'(got_e), 64'(exp_e));
    @(posedge clk); #1;
  endtask

  // Instance B: N=2, so out_valid rises after edge k+2.
  task automatic txn_b(input string name, input logic m, input logic [21:0] d,
                       input logic [21:0] exp_d, input logic exp_e);
    logic [22:0] mv;
    mv = model(m, d);
    check({name, "_idle"}, 64'(bus_b.in_ready), 64'd1);
    bus_b.in_valid = 1'b1;
    bus_b.in_mode  = m;
    bus_b.in_data  = d;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = ~d;
    check({name, "_v_k0"}, 64'(bus_b.out_valid), 64'd0);
    @(posedge clk); #1;
    check({name, "_v_k1"}, 64'(bus_b.out_valid), 64'd0);
    @(posedge clk); #1;
    check({name, "_v_k2"},  64'(bus_b.out_valid), 64'd1);
    check({name, "_data"},  64'(bus_b.out_data),  64'(exp_d));
    check({name, "_err"},   64'(bus_b.out_err),   64'(exp_e));
    check({name, "_model"}, 64'(bus_b.out_data),  64'(mv[21:0]));
    check({name, "_busy"},  64'(bus_b.in_ready),  64'd0);
    @(posedge clk); #1;
    check({name, "_release"}, 64'(bus_b.out_valid), 64'd0);
    check({name, "_ready"},   64'(bus_b.in_ready),  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] mv;
    logic [21:0] gd;
    logic        ge;
    int          acc0;
    int          done0;

    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_mode = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_mode = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Model pinned to hand-computed values.
    mv = model(MODE_ENC, 22'h200000);
    check("model_enc_80", 64'(mv), 64'h202EE3);
    mv = model(MODE_ENC, 22'h204000);
    check("model_enc_81", 64'(mv), 64'h206B7A);

    // Directed encode/check on instance A.
    txn_a("enc_80", MODE_ENC, 22'h200000, 22'h202EE3, 1'b0);
    txn_a("enc_01", MODE_ENC, 22'h007FFF, 22'h004599, 1'b0);
    txn_a("enc_00", MODE_ENC, 22'h000000, 22'h000000, 1'b0);
    txn_a("chk_ok", MODE_CHK, 22'h202EE3, 22'h202EE3, 1'b0);
    txn_a("chk_bad", MODE_CHK, 22'h202EE2, 22'h202EE2, 1'b1);

    // Backpressure: result must hold while out_ready is low.
    bus_a.out_ready = 1'b0;
    mv = model(MODE_ENC, 22'h168000);
    send_a(MODE_ENC, 22'h168000);
    wait_a(gd, ge);
    check("bp_first_data", 64'(gd), 64'(mv[21:0]));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", 64'(bus_a.out_valid), 64'd1);
      check("bp_data_hold",  64'(bus_a.out_data),  64'(mv[21:0]));
      check("bp_in_ready",   64'(bus_a.in_ready),  64'd0);
    end
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(bus_a.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus_a.in_ready),  64'd1);

    // Continuous in_valid with changing data: one accept per 3 cycles.
    acc0  = acc_a;
    done0 = done_a;
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus_a.in_mode = 1'($urandom_range(0, 1));
      bus_a.in_data = 22'($urandom);
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stream_accepts", 64'(acc_a - acc0),  64'd4);
    check("stream_results", 64'(done_a - done0), 64'd4);

    // Reset while in SHIFT abandons the transaction.
    send_a(MODE_ENC, 22'h200000);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready",  64'(bus_a.in_ready),  64'd1);
    check("mid_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("mid_rst_out_data",  64'(bus_a.out_data),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_output", 64'(bus_a.out_valid), 64'd0);
    txn_a("post_rst_enc_80", MODE_ENC, 22'h200000, 22'h202EE3, 1'b0);

    // Instance B (CHUNK_W=4).
    txn_b("b_enc_81", MODE_ENC, 22'h204000, 22'h206B7A, 1'b0);
    txn_b("b_chk_ok", MODE_CHK, 22'h206B7A, 22'h206B7A, 1'b0);
    txn_b("b_chk_bad", MODE_CHK, 22'h206B7B, 22'h206B7B, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
